register_file_writeback: RTL and testbench

- Architectural register file plus HI/LO register pair for the MIPS pipeline.
- Sink of the WriteBack stage: accepts WriteData and the Move qualifier, and commits register writes.
- Source of ReadDataHi/ReadDataLo back into WriteBack.
- Serves two combinational GPR read ports to Decode, with write-through bypass so same-cycle writeback is visible without a forwarding stall.

---
 rtl/register_file_writeback_if.sv | 48 ++++
 rtl/register_file_writeback.sv | 102 ++++++++++
 tb/tb_register_file_writeback.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_writeback_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : register_file_writeback_if
// Description : Bundle of the register file's read ports (Decode side), the
//               writeback commit inputs and the HI/LO pair. The master modport
//               is the pipeline side and the slave modport is the register
//               file.
//   Read ports  : ReadRegister1/2 -> ReadData1/2 (combinational)
//   GPR write   : WriteRegister, WriteData, RegWrite, Move
//   HI/LO write : HiLoWrite + HiLoResult, HiWrite/LoWrite (use WriteData)
//   HI/LO read  : ReadDataHi, ReadDataLo (bypassed)
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_writeback_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic [IDX_W-1:0]        ReadRegister1;
  logic [IDX_W-1:0]        ReadRegister2;
  logic [DATA_WIDTH-1:0]   ReadData1;
  logic [DATA_WIDTH-1:0]   ReadData2;
  logic [IDX_W-1:0]        WriteRegister;
  logic [DATA_WIDTH-1:0]   WriteData;
  logic                    RegWrite;
  logic                    Move;
  logic                    HiLoWrite;
  logic [2*DATA_WIDTH-1:0] HiLoResult;
  logic                    HiWrite;
  logic                    LoWrite;
  logic [DATA_WIDTH-1:0]   ReadDataHi;
  logic [DATA_WIDTH-1:0]   ReadDataLo;

  modport master (
    output ReadRegister1, ReadRegister2, WriteRegister, WriteData,
           RegWrite, Move, HiLoWrite, HiLoResult, HiWrite, LoWrite,
    input  ReadData1, ReadData2, ReadDataHi, ReadDataLo
  );

  modport slave (
    input  ReadRegister1, ReadRegister2, WriteRegister, WriteData,
           RegWrite, Move, HiLoWrite, HiLoResult, HiWrite, LoWrite,
    output ReadData1, ReadData2, ReadDataHi, ReadDataLo
  );
endinterface : register_file_writeback_if
`default_nettype wire

// File: rtl/register_file_writeback.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : register_file_writeback
// Description : MIPS architectural register file plus HI/LO pair. Commits
//               writeback results on the rising clock edge and serves two
//               combinational GPR read ports with write-through bypass, so a
//               value being written back is visible to Decode in the same
//               cycle. HI/LO reads are likewise bypassed.
//   Clk  : rising-edge clock
//   Rst  : asynchronous reset, active-low; clears GPRs, HI, LO and forces
//          every read output to 0 while asserted
//   bus  : register_file_writeback_if.slave (read ports, writeback, HI/LO)
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  wire logic                  Clk,
  input  wire logic                  Rst,
  register_file_writeback_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] r_gpr [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_lo;

  logic                  w_gprCommit;
  logic [DATA_WIDTH-1:0] w_hiNext;
  logic [DATA_WIDTH-1:0] w_loNext;

  // A failed conditional move (Move=0) or a write to R0 commits nothing and
  // must not bypass either. With RegWrite=0 the AND also masks an unknown Move.
  assign w_gprCommit = bus.RegWrite & bus.Move & (bus.WriteRegister != '0);

  // -------------------------------------------------------------------------
  // GPR storage. Entry 0 is only ever cleared, so it holds 0 permanently.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_gpr[i] <= '0;
      end
    end else if (w_gprCommit) begin
      r_gpr[bus.WriteRegister] <= bus.WriteData;
    end
  end

  // -------------------------------------------------------------------------
  // HI/LO next-state: the full 64-bit result outranks the single-half moves.
  // The same values drive the bypassed read outputs.
  // -------------------------------------------------------------------------
  always_comb begin
    w_hiNext = r_hi;
    w_loNext = r_lo;
    if (bus.HiLoWrite) begin
      w_hiNext = bus.HiLoResult[2*DATA_WIDTH-1:DATA_WIDTH];
      w_loNext = bus.HiLoResult[DATA_WIDTH-1:0];
    end else begin
      if (bus.HiWrite) begin
        w_hiNext = bus.WriteData;
      end
      if (bus.LoWrite) begin
        w_loNext = bus.WriteData;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      r_hi <= w_hiNext;
      r_lo <= w_loNext;
    end
  end

  // -------------------------------------------------------------------------
  // Read ports. Reset dominates so nothing leaks through the bypass while
  // Rst is low; R0 is forced to 0 regardless of what is being written.
  // -------------------------------------------------------------------------
  function automatic logic [DATA_WIDTH-1:0] readPort(input logic [IDX_W-1:0] idx);
    if (idx == '0) begin
      return '0;
    end else if (w_gprCommit && (bus.WriteRegister == idx)) begin
      return bus.WriteData;
    end else begin
      return r_gpr[idx];
    end
  endfunction

  assign bus.ReadData1  = Rst ? readPort(bus.ReadRegister1) : '0;
  assign bus.ReadData2  = Rst ? readPort(bus.ReadRegister2) : '0;
  assign bus.ReadDataHi = Rst ? w_hiNext : '0;
  assign bus.ReadDataLo = Rst ? w_loNext : '0;

endmodule : register_file_writeback
`default_nettype wire

// File: tb/tb_register_file_writeback.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_register_file_writeback
// Description : Self-checking bench for register_file_writeback. Directed
//               scenarios followed by randomized traffic checked against an
//               array-based reference model of the architectural state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_writeback;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference architectural state
  logic [31:0] mGpr [32];
  logic [31:0] mHi;
  logic [31:0] mLo;

  register_file_writeback_if #(.DATA_WIDTH(32), .NUM_REGS(32)) bus ();

  register_file_writeback #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp)
    else begin
      nMismatched++;
      $error("FAIL %0s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mGpr[i] = 32'h0;
    mHi = 32'h0;
    mLo = 32'h0;
  endtask

  // What a read port should show: R0 is zero, a qualified same-cycle write
  // is visible, otherwise the architectural value.
  function automatic logic [31:0] expRead(input logic [4:0] idx);
    if (Rst !== 1'b1) return 32'h0;
    if (idx == 5'd0) return 32'h0;
    if (bus.RegWrite === 1'b1 && bus.Move === 1'b1 && bus.WriteRegister == idx)
      return bus.WriteData;
    return mGpr[idx];
  endfunction

  function automatic logic [31:0] expHi();
    if (Rst !== 1'b1) return 32'h0;
    if (bus.HiLoWrite === 1'b1) return bus.HiLoResult[63:32];
    if (bus.HiWrite === 1'b1) return bus.WriteData;
    return mHi;
  endfunction

  function automatic logic [31:0] expLo();
    if (Rst !== 1'b1) return 32'h0;
    if (bus.HiLoWrite === 1'b1) return bus.HiLoResult[31:0];
    if (bus.LoWrite === 1'b1) return bus.WriteData;
    return mLo;
  endfunction

  // Apply the architectural update for the current inputs, then take the edge.
  task automatic clockIt();
    logic [31:0] nh;
    logic [31:0] nl;
    nh = expHi();
    nl = expLo();
    if (bus.RegWrite === 1'b1 && bus.Move === 1'b1 && bus.WriteRegister != 5'd0)
      mGpr[bus.WriteRegister] = bus.WriteData;
    mHi = nh;
    mLo = nl;
    @(posedge Clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.RegWrite   = 1'b0;
    bus.Move       = 1'b0;
    bus.HiLoWrite  = 1'b0;
    bus.HiWrite    = 1'b0;
    bus.LoWrite    = 1'b0;
    bus.HiLoResult = 64'h0;
    bus.WriteData  = 32'h0;
    bus.WriteRegister = 5'd0;
  endtask

  initial begin
    logic [4:0] r;
    modelReset();
    idleInputs();
    bus.ReadRegister1 = 5'd0;
    bus.ReadRegister2 = 5'd0;

    // ---- Reset held: bypass inputs must not leak, edge must not commit ----
    #2;
    bus.RegWrite = 1'b1; bus.Move = 1'b1;
    bus.WriteRegister = 5'd5; bus.WriteData = 32'hDEADBEEF;
    bus.ReadRegister1 = 5'd5; bus.ReadRegister2 = 5'd5;
    bus.HiLoWrite = 1'b1; bus.HiLoResult = 64'hFFFFFFFF_FFFFFFFF;
    #1;
    check("rst_rd1_bypass", bus.ReadData1, 32'h0);
    check("rst_hi_bypass", bus.ReadDataHi, 32'h0);
    check("rst_lo_bypass", bus.ReadDataLo, 32'h0);
    @(posedge Clk); #1;
    check("rst_rd1_edge", bus.ReadData1, 32'h0);
    idleInputs();
    #1 Rst = 1'b1;
    #1;
    check("rel_rd1", bus.ReadData1, 32'h0);
    check("rel_hi", bus.ReadDataHi, 32'h0);
    check("rel_lo", bus.ReadDataLo, 32'h0);
    clockIt();
    check("rel_r5_after", bus.ReadData1, 32'h0);

    // ---- Basic write/read and R0 ----
    bus.RegWrite = 1'b1; bus.Move = 1'b1;
    bus.WriteRegister = 5'd8; bus.WriteData = 32'h12345678;
    clockIt();
    idleInputs();
    bus.ReadRegister1 = 5'd8; bus.ReadRegister2 = 5'd8;
    #1;
    check("r8_p1", bus.ReadData1, 32'h12345678);
    check("r8_p2", bus.ReadData2, 32'h12345678);
    bus.RegWrite = 1'b1; bus.Move = 1'b1;
    bus.WriteRegister = 5'd0; bus.WriteData = 32'h0000FFFF;
    bus.ReadRegister1 = 5'd0;
    #1;
    check("r0_bypass", bus.ReadData1, 32'h0);
    clockIt();
    idleInputs();
    #1;
    check("r0_stored", bus.ReadData1, 32'h0);

    // ---- Failed conditional move ----
    bus.RegWrite = 1'b1; bus.Move = 1'b1;
    bus.WriteRegister = 5'd9; bus.WriteData = 32'h0000AAAA;
    clockIt();
    bus.Move = 1'b0; bus.WriteData = 32'h00005555;
    bus.ReadRegister1 = 5'd9;
    #1;
    check("movfail_same", bus.ReadData1, 32'h0000AAAA);
    clockIt();
    check("movfail_after", bus.ReadData1, 32'h0000AAAA);

    // ---- Dual-port bypass ----
    bus.ReadRegister1 = 5'd10; bus.ReadRegister2 = 5'd10;
    bus.RegWrite = 1'b1; bus.Move = 1'b1;
    bus.WriteRegister = 5'd10; bus.WriteData = 32'hCAFEF00D;
    #1;
    check("byp_p1", bus.ReadData1, 32'hCAFEF00D);
    check("byp_p2", bus.ReadData2, 32'hCAFEF00D);
    clockIt();
    idleInputs();
    #1;
    check("byp_p1_held", bus.ReadData1, 32'hCAFEF00D);
    check("byp_p2_held", bus.ReadData2, 32'hCAFEF00D);

    // ---- HI/LO priority ----
    bus.HiLoWrite = 1'b1; bus.HiLoResult = 64'h00000001_FFFFFFFE;
    bus.HiWrite = 1'b1; bus.WriteData = 32'h7;
    #1;
    check("hilo_hi_byp", bus.ReadDataHi, 32'h1);
    check("hilo_lo_byp", bus.ReadDataLo, 32'hFFFFFFFE);
    clockIt();
    idleInputs();
    #1;
    check("hilo_hi_st", bus.ReadDataHi, 32'h1);
    check("hilo_lo_st", bus.ReadDataLo, 32'hFFFFFFFE);
    bus.LoWrite = 1'b1; bus.WriteData = 32'h42;
    #1;
    check("mtlo_lo_byp", bus.ReadDataLo, 32'h42);
    check("mtlo_hi_keep", bus.ReadDataHi, 32'h1);
    clockIt();
    idleInputs();
    #1;
    check("mtlo_lo_st", bus.ReadDataLo, 32'h42);
    check("mtlo_hi_st", bus.ReadDataHi, 32'h1);

    // ---- Reset mid-operation ----
    bus.RegWrite = 1'b1; bus.Move = 1'b1;
    bus.WriteRegister = 5'd3; bus.WriteData = 32'h00000033;
    clockIt();
    bus.WriteData = 32'h00000099;
    bus.ReadRegister1 = 5'd3;
    #2 Rst = 1'b0;
    modelReset();
    #1;
    check("midrst_r3", bus.ReadData1, 32'h0);
    check("midrst_hi", bus.ReadDataHi, 32'h0);
    check("midrst_lo", bus.ReadDataLo, 32'h0);
    @(posedge Clk); #1;
    idleInputs();
    #1 Rst = 1'b1;
    #1;
    check("midrst_r3_rel", bus.ReadData1, 32'h0);
    check("midrst_hi_rel", bus.ReadDataHi, 32'h0);
    check("midrst_lo_rel", bus.ReadDataLo, 32'h0);
    bus.ReadRegister1 = 5'd8;
    #1;
    check("midrst_r8_clr", bus.ReadData1, 32'h0);

    // ---- Randomized traffic against the model ----
    for (int n = 0; n < 300; n++) begin
      bus.RegWrite      = 1'($urandom_range(0, 1));
      bus.WriteRegister = 5'($urandom_range(0, 31));
      bus.WriteData     = $urandom;
      if (bus.RegWrite == 1'b0 && $urandom_range(0, 3) == 0)
        bus.Move = 1'bx;
      else
        bus.Move = ($urandom_range(0, 3) != 0);
      bus.HiLoWrite  = ($urandom_range(0, 4) == 0);
      bus.HiLoResult = {$urandom, $urandom};
      bus.HiWrite    = ($urandom_range(0, 3) == 0);
      bus.LoWrite    = ($urandom_range(0, 3) == 0);
      bus.ReadRegister1 = ($urandom_range(0, 2) == 0) ? bus.WriteRegister : 5'($urandom_range(0, 31));
      bus.ReadRegister2 = ($urandom_range(0, 2) == 0) ? bus.WriteRegister : 5'($urandom_range(0, 31));
      #1;
      check("rnd_rd1", bus.ReadData1, expRead(bus.ReadRegister1));
      check("rnd_rd2", bus.ReadData2, expRead(bus.ReadRegister2));
      check("rnd_hi", bus.ReadDataHi, expHi());
      check("rnd_lo", bus.ReadDataLo, expLo());
      clockIt();
    end

    // ---- Final sweep of stored state ----
    idleInputs();
    for (int i = 0; i < 32; i++) begin
      r = 5'(i);
      bus.ReadRegister1 = r;
      bus.ReadRegister2 = 5'(31 - i);
      #1;
      check("sweep_p1", bus.ReadData1, (i == 0) ? 32'h0 : mGpr[i]);
      check("sweep_p2", bus.ReadData2, (i == 31) ? 32'h0 : mGpr[31 - i]);
    end
    check("sweep_hi", bus.ReadDataHi, mHi);
    check("sweep_lo", bus.ReadDataLo, mLo);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule : tb_register_file_writeback
`default_nettype wire
